// File: rtl/sb_rx_msg_queue_pkg.sv
// rtl/sb_rx_msg_queue_pkg.sv - sideband message types and parity helpers for the RX message queue
package sb_rx_msg_queue_pkg;

    localparam int SB_DATA_W = 64;

    // Sideband opcodes seen by the RX queue; only OP_MSG_64B carries a payload.
    typedef enum logic [4:0] {
        OP_NONE        = 5'h00,
        OP_MSG_NO_DATA = 5'h12,
        OP_MSG_64B     = 5'h1B
    } sb_opcode_e;

    // Decoded message identities used by the LTSM state blocks.
    typedef enum logic [7:0] {
        NO_MSG                   = 8'h00,
        SBINIT_out_of_reset      = 8'h01,
        SBINIT_done_req          = 8'h02,
        SBINIT_done_resp         = 8'h03,
        MBINIT_PARAM_config_req  = 8'h04,
        MBINIT_PARAM_config_resp = 8'h05,
        MBINIT_CAL_done_req      = 8'h06,
        MBINIT_CAL_done_resp     = 8'h07
    } sb_msg_num_e;

    // Decoded header: cp covers msg_num/opcode/msg_info, dp covers the payload.
    typedef struct packed {
        sb_msg_num_e msg_num;
        sb_opcode_e  opcode;
        logic [15:0] msg_info;
        logic        cp;
        logic        dp;
    } SB_msg_t;

    localparam int SB_MSG_W = $bits(SB_msg_t);

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m = '0;
        return m;
    endfunction

    // Even parity over every header field except the parity bits themselves.
    function automatic logic sb_calc_cp(input SB_msg_t m);
        return ^{m.msg_num, m.opcode, m.msg_info};
    endfunction

    function automatic logic sb_opcode_has_data(input sb_opcode_e op);
        return op == OP_MSG_64B;
    endfunction

endpackage

// File: rtl/sb_sync_fifo.sv
// rtl/sb_sync_fifo.sv - single-clock FIFO with flush, MSB-compare full/empty
module sb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    // Pointer update; flush returns both pointers to the origin.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sb_rx_msg_queue.sv
// rtl/sb_rx_msg_queue.sv - sideband RX message queue with parity check and req/valid delivery
module sb_rx_msg_queue
    import sb_rx_msg_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic                 flush_i,
    input  logic                 deser_msg_valid_i,
    input  SB_msg_t              deser_msg_i,
    input  logic [SB_DATA_W-1:0] deser_data_i,
    output logic                 SB_RX_msg_available_o,
    input  logic                 SB_RX_msg_req_i,
    output logic                 SB_RX_msg_valid_o,
    output SB_msg_t              SB_RX_msg_o,
    output logic [SB_DATA_W-1:0] SB_RX_dataBus_o,
    output logic [CNT_W-1:0]     parity_err_cnt_o,
    output logic                 overflow_o
);
    localparam int ENTRY_W = SB_MSG_W + SB_DATA_W;
    localparam int PW      = $clog2(DEPTH) + 1;

    typedef enum logic {ST_IDLE, ST_DELIVER} state_e;
    state_e state;

    logic               has_data;
    logic               cp_ok;
    logic               dp_ok;
    logic               parity_ok;
    logic               ingress;
    logic               push_req;
    logic               push_acc;
    logic               pop;
    logic               avail_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PW-1:0]      fifo_count;
    logic [PW-1:0]      count_next;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    SB_msg_t            head_msg;
    logic [SB_DATA_W-1:0] head_data;

    assign has_data  = sb_opcode_has_data(deser_msg_i.opcode);
    assign cp_ok     = (deser_msg_i.cp == sb_calc_cp(deser_msg_i));
    assign dp_ok     = !has_data || (deser_msg_i.dp == ^deser_data_i);
    assign parity_ok = cp_ok && dp_ok;
    assign ingress   = enable_i && deser_msg_valid_i;

    // Flush discards both the incoming message and any pop attempted alongside it.
    assign push_req  = ingress && parity_ok && !flush_i;
    assign pop       = enable_i && !flush_i && (state == ST_IDLE) && SB_RX_msg_req_i && !fifo_empty;
    assign push_acc  = push_req && (!fifo_full || pop);

    // Payload is zeroed for no-data opcodes so consumers never see stale deser bits.
    assign push_entry = {deser_msg_i, has_data ? deser_data_i : {SB_DATA_W{1'b0}}};
    assign head_msg   = SB_msg_t'(head_entry[ENTRY_W-1:SB_DATA_W]);
    assign head_data  = head_entry[SB_DATA_W-1:0];

    // Occupancy after this edge; a pop moves the FSM to DELIVER, which masks availability.
    assign count_next = fifo_count + {{(PW-1){1'b0}}, push_acc} - {{(PW-1){1'b0}}, pop};
    assign avail_next = enable_i && !flush_i && !pop && (count_next != '0);

    sb_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_100MHz),
        .reset (reset),
        .push  (push_req),
        .wdata (push_entry),
        .pop   (pop),
        .flush (flush_i),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Delivery FSM: one-cycle valid pulse per pop, delivered fields held afterwards.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state                 <= ST_IDLE;
            SB_RX_msg_valid_o     <= 1'b0;
            SB_RX_msg_available_o <= 1'b0;
            SB_RX_msg_o           <= reset_SB_msg();
            SB_RX_dataBus_o       <= '0;
        end else begin
            SB_RX_msg_available_o <= avail_next;
            SB_RX_msg_valid_o     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state             <= ST_DELIVER;
                        SB_RX_msg_valid_o <= 1'b1;
                        SB_RX_msg_o       <= head_msg;
                        SB_RX_dataBus_o   <= head_data;
                    end
                end
                ST_DELIVER: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Error bookkeeping: saturating parity-drop count and sticky overflow flag.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            parity_err_cnt_o <= '0;
            overflow_o       <= 1'b0;
        end else begin
            if (ingress && !parity_ok && (parity_err_cnt_o != '1))
                parity_err_cnt_o <= parity_err_cnt_o + 1'b1;
            if (push_req && fifo_full && !pop)
                overflow_o <= 1'b1;
        end
    end

endmodule
